fp_normalize_pack: RTL and testbench

- Back end of the FP adder datapath. Takes the raw signed-magnitude sum produced from the aligned mantissas: sign, shared exponent, and an extended mantissa carrying a carry bit, hidden bit, fraction and protect bits.
- Normalizes iteratively, one left shift per cycle, then rounds to nearest-even and packs an IEEE word in `data_format`.
- valid/ready on both sides; one operation in flight.

---
 rtl/fp_normalize_pack_pkg.sv | 69 ++++++
 rtl/fp_normalize_pack_if.sv | 43 ++++
 rtl/fp_round_rne.sv | 45 ++++
 rtl/fp_normalize_pack.sv | 193 +++++++++++++++++++
 tb/tb_fp_normalize_pack.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_normalize_pack_pkg.sv
// ---------------------------------------------------------------------------
// fp_normalize_pack_pkg
//   Shared format helpers and types for the FP adder back end.
//   Format selectors: FP16, FP32, FP64.
//   get_* helpers return field widths for a given format selector:
//     get_fp_len        total IEEE word width
//     get_exp_len       exponent field width
//     get_mantissa_len  stored fraction width (hidden bit excluded)
//     get_protect_len   guard/round/sticky bits carried below the fraction
//     get_guard_bit     index of the guard bit inside the sum mantissa
//     get_sum_mant_len  {carry, hidden, frac, protect} width
//   state_t: normalize/pack FSM state encoding.
// ---------------------------------------------------------------------------
package fp_normalize_pack_pkg;

    localparam int FP16 = 0;
    localparam int FP32 = 1;
    localparam int FP64 = 2;

    function automatic int get_fp_len(input int fmt);
        case (fmt)
            FP16:    return 16;
            FP64:    return 64;
            default: return 32;
        endcase
    endfunction

    function automatic int get_exp_len(input int fmt);
        case (fmt)
            FP16:    return 5;
            FP64:    return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int get_mantissa_len(input int fmt);
        case (fmt)
            FP16:    return 10;
            FP64:    return 52;
            default: return 23;
        endcase
    endfunction

    // Guard, round and one sticky bit are enough for round-to-nearest-even.
    function automatic int get_protect_len(input int fmt);
        case (fmt)
            FP16:    return 3;
            FP64:    return 3;
            default: return 3;
        endcase
    endfunction

    function automatic int get_guard_bit(input int fmt);
        return get_protect_len(fmt) - 1;
    endfunction

    function automatic int get_sum_mant_len(input int fmt);
        return get_mantissa_len(fmt) + get_protect_len(fmt) + 2;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/fp_normalize_pack_if.sv
// ---------------------------------------------------------------------------
// fp_normalize_pack_if
//   Upstream and downstream handshakes of the normalize/pack stage.
//   Upstream  : in_valid, in_ready, in_sign, in_exp, in_mant
//   Downstream: out_valid, out_ready, out_result, out_overflow, out_inexact
//   Handshake: a transfer happens on a rising clock edge where valid and
//   ready are both high; the sender keeps valid and its data stable until
//   that edge, and ready may depend on the receiver's state only.
//   Modports: master = producer of operands / consumer of results,
//             slave  = the normalize/pack block.
// ---------------------------------------------------------------------------
interface fp_normalize_pack_if
    import fp_normalize_pack_pkg::*;
#(
    parameter int data_format = FP32
);
    localparam int FP_LEN   = get_fp_len(data_format);
    localparam int EXP_LEN  = get_exp_len(data_format);
    localparam int SUM_LEN  = get_sum_mant_len(data_format);

    logic               in_valid;
    logic               in_ready;
    logic               in_sign;
    logic [EXP_LEN-1:0] in_exp;
    logic [SUM_LEN-1:0] in_mant;

    logic               out_valid;
    logic               out_ready;
    logic [FP_LEN-1:0]  out_result;
    logic               out_overflow;
    logic               out_inexact;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_inexact
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_inexact
    );

endinterface

// File: rtl/fp_round_rne.sv
// ---------------------------------------------------------------------------
// fp_round_rne
//   Combinational round-to-nearest-even of a normalized (or subnormal)
//   mantissa that still carries its protect bits.
//   mant_in    {hidden, frac, protect}
//   mant_out   {hidden, frac} after rounding
//   mant_carry rounding carried out of the hidden bit; mant_out is then
//              1.000... and the caller must bump its exponent
//   inexact    any nonzero protect bit was discarded
// ---------------------------------------------------------------------------
module fp_round_rne #(
    parameter int MANT_LEN    = 23,
    parameter int PROTECT_LEN = 3
) (
    input  logic [MANT_LEN+PROTECT_LEN:0] mant_in,
    output logic [MANT_LEN:0]             mant_out,
    output logic                          mant_carry,
    output logic                          inexact
);

    logic              guard_bit;
    logic              round_bit;
    logic              sticky_bit;
    logic              lsb_bit;
    logic              inc;
    logic [MANT_LEN+1:0] sum;

    assign guard_bit  = mant_in[PROTECT_LEN-1];
    assign round_bit  = mant_in[PROTECT_LEN-2];
    assign sticky_bit = |mant_in[PROTECT_LEN-3:0];
    assign lsb_bit    = mant_in[PROTECT_LEN];

    // Exact ties round up only when the kept LSB is odd.
    assign inc = guard_bit & (round_bit | sticky_bit | lsb_bit);

    assign sum = {1'b0, mant_in[MANT_LEN+PROTECT_LEN:PROTECT_LEN]}
               + {{(MANT_LEN+1){1'b0}}, inc};

    // A subnormal whose fraction overflows lands on hidden=1 without a carry
    // out, which is exactly the promotion to the smallest normal.
    assign mant_carry = sum[MANT_LEN+1];
    assign mant_out   = mant_carry ? {1'b1, {MANT_LEN{1'b0}}} : sum[MANT_LEN:0];
    assign inexact    = guard_bit | round_bit | sticky_bit;

endmodule

// File: rtl/fp_normalize_pack.sv
// ---------------------------------------------------------------------------
// fp_normalize_pack
//   Back end of the FP adder: takes the signed-magnitude sum of the aligned
//   mantissas, normalizes it one left shift per cycle, rounds to nearest
//   even and packs an IEEE word. One operation in flight at a time.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     io          fp_normalize_pack_if.slave (operand in, result out)
//     dbg_state   current FSM state
//   Flow: IDLE -accept-> PRE -> [NORM x k] -> ROUND -> DONE -handshake-> IDLE
//   Inf/NaN and zero inputs go straight from PRE to DONE.
// ---------------------------------------------------------------------------
module fp_normalize_pack
    import fp_normalize_pack_pkg::*;
#(
    parameter int data_format = FP32
) (
    input  logic                clk,
    input  logic                rst_n,
    fp_normalize_pack_if.slave  io,
    output state_t              dbg_state
);

    localparam int FP_LEN     = get_fp_len(data_format);
    localparam int EXP_LEN    = get_exp_len(data_format);
    localparam int MANT_LEN   = get_mantissa_len(data_format);
    localparam int PROT_LEN   = get_protect_len(data_format);
    localparam int SUM_LEN    = get_sum_mant_len(data_format);
    localparam int CARRY_BIT  = SUM_LEN - 1;
    localparam int HIDDEN_BIT = SUM_LEN - 2;
    // One extra exponent bit so carries past all-ones never wrap.
    localparam int WE_W       = EXP_LEN + 1;

    localparam logic [WE_W-1:0] WE_ONE = {{(WE_W-1){1'b0}}, 1'b1};
    localparam logic [WE_W-1:0] WE_INF = {1'b0, {EXP_LEN{1'b1}}};

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic [WE_W-1:0]     we_q, we_d;
    logic [SUM_LEN-1:0]  mant_q, mant_d;
    logic                out_valid_q, out_valid_d;
    logic [FP_LEN-1:0]   result_q, result_d;
    logic                ovf_q, ovf_d;
    logic                inex_q, inex_d;

    logic [SUM_LEN-1:0]  mant_shl;
    logic [WE_W-1:0]     we_dec;
    logic [MANT_LEN:0]   rnd_mant;
    logic                rnd_carry;
    logic                rnd_inexact;
    logic [WE_W-1:0]     we_rnd;
    logic [EXP_LEN-1:0]  exp_field;

    // -----------------------------------------------------------------------
    // Datapath helpers
    // -----------------------------------------------------------------------
    assign mant_shl = {mant_q[SUM_LEN-2:0], 1'b0};
    assign we_dec   = we_q - WE_ONE;

    fp_round_rne #(
        .MANT_LEN    (MANT_LEN),
        .PROTECT_LEN (PROT_LEN)
    ) u_round (
        .mant_in    (mant_q[HIDDEN_BIT:0]),
        .mant_out   (rnd_mant),
        .mant_carry (rnd_carry),
        .inexact    (rnd_inexact)
    );

    assign we_rnd    = we_q + {{(WE_W-1){1'b0}}, rnd_carry};
    // Subnormals (hidden still clear after rounding) encode exponent 0.
    assign exp_field = rnd_mant[MANT_LEN] ? we_rnd[EXP_LEN-1:0] : '0;

    // -----------------------------------------------------------------------
    // FSM: next state and next register values
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        we_d        = we_q;
        mant_d      = mant_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        inex_d      = inex_q;

        case (state_q)
            ST_IDLE: begin
                if (io.in_valid) begin
                    sign_d  = io.in_sign;
                    // Subnormals share the scale of exponent 1.
                    we_d    = (io.in_exp == '0) ? WE_ONE : {1'b0, io.in_exp};
                    mant_d  = io.in_mant;
                    state_d = ST_PRE;
                end
            end

            ST_PRE: begin
                if (we_q == WE_INF) begin
                    // Inf/NaN: keep the payload, no flags.
                    result_d    = {sign_q, {EXP_LEN{1'b1}},
                                   mant_q[HIDDEN_BIT-1:PROT_LEN]};
                    ovf_d       = 1'b0;
                    inex_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (mant_q == '0) begin
                    result_d    = {sign_q, {(FP_LEN-1){1'b0}}};
                    ovf_d       = 1'b0;
                    inex_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (mant_q[CARRY_BIT]) begin
                    // Right shift by one, folding the lost bit into sticky.
                    mant_d  = {1'b0, mant_q[SUM_LEN-1:2], mant_q[1] | mant_q[0]};
                    we_d    = we_q + WE_ONE;
                    state_d = ST_ROUND;
                end else if (mant_q[HIDDEN_BIT] || (we_q == WE_ONE)) begin
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_NORM;
                end
            end

            ST_NORM: begin
                mant_d = mant_shl;
                we_d   = we_dec;
                // Stop once normalized or at the subnormal exponent floor.
                if (mant_shl[HIDDEN_BIT] || (we_dec == WE_ONE)) begin
                    state_d = ST_ROUND;
                end
            end

            ST_ROUND: begin
                if (we_rnd >= WE_INF) begin
                    result_d = {sign_q, {EXP_LEN{1'b1}}, {MANT_LEN{1'b0}}};
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_field, rnd_mant[MANT_LEN-1:0]};
                    ovf_d    = 1'b0;
                end
                inex_d      = rnd_inexact;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end

            ST_DONE: begin
                if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and working registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            we_q        <= '0;
            mant_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            inex_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            we_q        <= we_d;
            mant_q      <= mant_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            inex_q      <= inex_d;
        end
    end

    assign io.in_ready     = (state_q == ST_IDLE);
    assign io.out_valid    = out_valid_q;
    assign io.out_result   = result_q;
    assign io.out_overflow = ovf_q;
    assign io.out_inexact  = inex_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// ---------------------------------------------------------------------------
// tb_fp_normalize_pack
//   Directed cases with literal expectations, then randomized operands
//   checked against an arithmetic reference model of normalize/round/pack.
// ---------------------------------------------------------------------------
module tb_fp_normalize_pack;
    import fp_normalize_pack_pkg::*;

    localparam int FMT      = FP32;
    localparam int FP_LEN   = get_fp_len(FMT);
    localparam int EXP_LEN  = get_exp_len(FMT);
    localparam int MANT_LEN = get_mantissa_len(FMT);
    localparam int PROT_LEN = get_protect_len(FMT);
    localparam int SUM_LEN  = get_sum_mant_len(FMT);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_normalize_pack_if #(.data_format(FMT)) io ();
    state_t dbg_state;

    fp_normalize_pack #(.data_format(FMT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io        (io),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [FP_LEN+1:0] exp_q[$];   // {overflow, inexact, result}
    int                lat_q[$];   // cycles from accept edge to out_valid

    task automatic check_eq(input string tag, input logic [63:0] act,
                            input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
        end
    endtask

    // Reference model: value-level normalize, RNE on the integer mantissa,
    // then pack. Returns the expected latency as well.
    task automatic model(input logic s, input logic [EXP_LEN-1:0] e_in,
                         input logic [SUM_LEN-1:0] m_in,
                         output logic [FP_LEN-1:0] res, output logic ovf,
                         output logic inex, output int lat);
        longint e, m, q, rem, half, expf, r, exp_max, frac_mask;
        int k;
        exp_max   = (longint'(1) << EXP_LEN) - 1;
        frac_mask = (longint'(1) << MANT_LEN) - 1;
        e = longint'(e_in);
        m = longint'(m_in);
        ovf = 1'b0;
        inex = 1'b0;
        k = 0;
        if (e == exp_max) begin
            r   = (longint'(s) << (FP_LEN-1)) | (exp_max << MANT_LEN)
                | ((m >> PROT_LEN) & frac_mask);
            res = r[FP_LEN-1:0];
            lat = 1;
        end else if (m == 0) begin
            r   = longint'(s) << (FP_LEN-1);
            res = r[FP_LEN-1:0];
            lat = 1;
        end else begin
            if (e == 0) e = 1;
            if (m >= (longint'(1) << (SUM_LEN-1))) begin
                m = (m >> 1) | (m & 1);
                e = e + 1;
            end else begin
                while (m < (longint'(1) << (SUM_LEN-2)) && e > 1) begin
                    m = m << 1;
                    e = e - 1;
                    k++;
                end
            end
            q    = m >> PROT_LEN;
            rem  = m & ((longint'(1) << PROT_LEN) - 1);
            half = longint'(1) << (PROT_LEN-1);
            inex = (rem != 0);
            if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
            if (q == (longint'(1) << (MANT_LEN+1))) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= exp_max) begin
                ovf = 1'b1;
                r   = (longint'(s) << (FP_LEN-1)) | (exp_max << MANT_LEN);
            end else begin
                expf = (q >= (longint'(1) << MANT_LEN)) ? e : 0;
                r    = (longint'(s) << (FP_LEN-1)) | (expf << MANT_LEN)
                     | (q & frac_mask);
            end
            res = r[FP_LEN-1:0];
            lat = 2 + k;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_op(input logic s, input logic [EXP_LEN-1:0] e,
                            input logic [SUM_LEN-1:0] m);
        int t;
        t = 0;
        @(negedge clk);
        io.in_valid = 1'b1;
        io.in_sign  = s;
        io.in_exp   = e;
        io.in_mant  = m;
        while (!io.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq("accept_ready", 64'(io.in_ready), 64'd1);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.in_sign  = 1'(  $urandom);
        io.in_exp   = EXP_LEN'($urandom);
        io.in_mant  = SUM_LEN'($urandom);
    endtask

    // ---------------- monitor ----------------
    task automatic collect(input string tag, input int hold, input bit junk);
        logic [FP_LEN+1:0] ev;
        int lat_exp, cyc;
        bit rdy_seen;
        ev      = exp_q.pop_front();
        lat_exp = lat_q.pop_front();
        cyc = 0;
        rdy_seen = 1'b0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (io.in_ready) rdy_seen = 1'b1;
        end while (!io.out_valid && cyc < 200);
        check_eq({tag, "_lat"},  64'(cyc), 64'(lat_exp));
        check_eq({tag, "_res"},  64'(io.out_result), 64'(ev[FP_LEN-1:0]));
        check_eq({tag, "_ovf"},  64'(io.out_overflow), 64'(ev[FP_LEN+1]));
        check_eq({tag, "_inex"}, 64'(io.out_inexact), 64'(ev[FP_LEN]));
        check_eq({tag, "_busy"}, 64'(rdy_seen), 64'd0);
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                io.in_valid = 1'b1;
                io.in_sign  = 1'($urandom);
                io.in_exp   = EXP_LEN'($urandom_range(1, 200));
                io.in_mant  = SUM_LEN'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, "_hold"}, {31'd0, io.out_valid, io.out_result},
                     {31'd0, 1'b1, ev[FP_LEN-1:0]});
        end
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        io.in_valid  = 1'b0;
    endtask

    task automatic run_dir(input string tag, input logic s,
                           input logic [EXP_LEN-1:0] e,
                           input logic [SUM_LEN-1:0] m,
                           input logic [FP_LEN-1:0] res, input logic ovf,
                           input logic inex, input int lat, input int hold,
                           input bit junk);
        exp_q.push_back({ovf, inex, res});
        lat_q.push_back(lat);
        drive_op(s, e, m);
        collect(tag, hold, junk);
    endtask

    task automatic run_rnd(input logic s, input logic [EXP_LEN-1:0] e,
                           input logic [SUM_LEN-1:0] m);
        logic [FP_LEN-1:0] res;
        logic ovf, inex;
        int lat;
        model(s, e, m, res, ovf, inex, lat);
        exp_q.push_back({ovf, inex, res});
        lat_q.push_back(lat);
        drive_op(s, e, m);
        collect("rnd", $urandom_range(0, 2), 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [EXP_LEN-1:0] re;
        logic [SUM_LEN-1:0] rm;
        logic rs;

        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.in_sign   = 1'b0;
        io.in_exp    = '0;
        io.in_mant   = '0;
        io.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready",  64'(io.in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(io.out_valid), 64'd0);
        check_eq("rst_result",    64'(io.out_result), 64'd0);
        check_eq("rst_flags",     64'({io.out_overflow, io.out_inexact}), 64'd0);
        check_eq("rst_state",     64'(dbg_state), 64'(ST_IDLE));
        rst_n = 1'b1;

        // Directed cases (FP32 sum mantissa: carry 27, hidden 26, frac 25:3, protect 2:0)
        run_dir("one_plus_one", 1'b0, 8'd127, 28'h800_0000, 32'h4000_0000, 1'b0, 1'b0, 2, 0, 1'b0);
        run_dir("cancel3",      1'b0, 8'd127, 28'h080_0000, 32'h3E00_0000, 1'b0, 1'b0, 5, 0, 1'b0);
        run_dir("tie_up",       1'b0, 8'd127, 28'h7FF_FFFC, 32'h4000_0000, 1'b0, 1'b1, 2, 0, 1'b0);
        run_dir("tie_even",     1'b0, 8'd127, 28'h400_0014, 32'h3F80_0002, 1'b0, 1'b1, 2, 0, 1'b0);
        run_dir("overflow",     1'b0, 8'd254, 28'h800_0000, 32'h7F80_0000, 1'b1, 1'b0, 2, 0, 1'b0);
        run_dir("inf_pass",     1'b0, 8'd255, 28'h400_0000, 32'h7F80_0000, 1'b0, 1'b0, 1, 0, 1'b0);
        run_dir("subnormal",    1'b0, 8'd1,   28'h200_0000, 32'h0040_0000, 1'b0, 1'b0, 2, 0, 1'b0);
        run_dir("neg_zero",     1'b1, 8'd50,  28'h000_0000, 32'h8000_0000, 1'b0, 1'b0, 1, 0, 1'b0);
        // Backpressure: result held for 5 cycles while junk operands are offered.
        run_dir("backpressure", 1'b1, 8'd127, 28'h800_0000, 32'hC000_0000, 1'b0, 1'b0, 2, 5, 1'b1);
        repeat (2) @(negedge clk);
        check_eq("bp_no_accept", 64'({io.out_valid, io.in_ready}), 64'b01);

        // Randomized operands against the reference model.
        for (int n = 0; n < 150; n++) begin
            rs = 1'($urandom);
            case ($urandom_range(0, 9))
                0:       re = '0;
                1:       re = 8'd1;
                2:       re = 8'd254;
                3:       re = 8'd255;
                4:       re = 8'($urandom_range(2, 5));
                default: re = 8'($urandom_range(1, 254));
            endcase
            rm = SUM_LEN'($urandom) >> $urandom_range(0, SUM_LEN-1);
            if ($urandom_range(0, 7) == 0) rm = '0;
            run_rnd(rs, re, rm);
        end

        // Reset in the middle of a long normalization.
        drive_op(1'b0, 8'd127, 28'h000_0008);
        repeat (5) @(negedge clk);
        check_eq("pre_rst_state", 64'(dbg_state), 64'(ST_NORM));
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(io.out_valid), 64'd0);
        check_eq("mid_rst_ready", 64'(io.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_dir("post_rst", 1'b0, 8'd127, 28'h800_0000, 32'h4000_0000, 1'b0, 1'b0, 2, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
